// File: rtl/mips_lite_mc_core_if.sv
// Memory-side handshake bundle of the multi-cycle MIPS-lite core.
// The core drives the master modport. Memories or models drive the slave modport.
interface mips_lite_mc_core_if #(
    parameter int ADDR_W = 8
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic              imem_ready;
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [31:0]       dmem_wdata;
    logic [31:0]       dmem_rdata;
    logic              dmem_ready;

    modport master (
        output imem_req, imem_addr,
        input  imem_rdata, imem_ready,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rdata, imem_ready,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_ready
    );
endinterface

// File: rtl/mips_lite_mc_core.sv
// Multi-cycle MIPS-lite core: one FSM steps FETCH/DECODE/EXEC/MEM/WB around a single shared ALU.
// Instruction and data memories sit behind req/ready handshakes.
module mips_lite_mc_core #(
    parameter int ADDR_W    = 8,
    parameter int NREG_LOG2 = 5,
    parameter int RESET_PC  = 0,
    parameter int LINK_REG  = 25
) (
    input  logic                clk,
    input  logic                rst_n,
    mips_lite_mc_core_if.master bus,
    output logic [2:0]          flags,
    output logic                halted,
    output logic                illegal,
    output logic [31:0]         retired
);
    localparam int NREG = 1 << NREG_LOG2;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_REGIMM = 6'h01, OP_J  = 6'h02, OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D, OP_LW     = 6'h23, OP_SW = 6'h2B, OP_HALT = 6'h3F;
    localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25, F_SLT = 6'h2A;
    localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2, ALU_OR = 3'd3, ALU_SLT = 3'd4;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d, t_q, t_d;
    logic [31:0]        ir_q, ir_d, a_q, a_d, b_q, b_d, alu_q, alu_d, mdr_q, mdr_d;
    logic [2:0]         flags_q, flags_d;
    logic               halted_q, halted_d, illegal_q, illegal_d;
    logic [31:0]        retired_q, retired_d;
    logic [31:0]        rf_q [NREG];
    logic               rf_we;
    logic [NREG_LOG2-1:0] rf_waddr;
    logic [31:0]        rf_wdata;

    logic [5:0]           opcode, funct;
    logic [NREG_LOG2-1:0] rs_idx, rt_idx, rd_idx;
    logic [31:0]          imm_sext, imm_zext;
    logic                 rtype_ok, is_bltzal, op_legal;

    assign opcode    = ir_q[31:26];
    assign funct     = ir_q[5:0];
    assign rs_idx    = ir_q[21 +: NREG_LOG2];
    assign rt_idx    = ir_q[16 +: NREG_LOG2];
    assign rd_idx    = ir_q[11 +: NREG_LOG2];
    assign imm_sext  = {{16{ir_q[15]}}, ir_q[15:0]};
    assign imm_zext  = {16'h0000, ir_q[15:0]};
    assign rtype_ok  = (funct == F_ADD) || (funct == F_SUB) || (funct == F_AND) ||
                       (funct == F_OR)  || (funct == F_SLT);
    assign is_bltzal = (opcode == OP_REGIMM) && (ir_q[20:16] == 5'b10000);
    assign op_legal  = ((opcode == OP_RTYPE) && rtype_ok) || is_bltzal ||
                       (opcode inside {OP_J, OP_BEQ, OP_ORI, OP_LW, OP_SW, OP_HALT});

    // Requests are gated by rst_n so they drop the instant reset asserts.
    assign bus.imem_req   = rst_n && (state_q == S_FETCH);
    assign bus.imem_addr  = pc_q;
    assign bus.dmem_req   = rst_n && (state_q == S_MEM);
    assign bus.dmem_we    = rst_n && (state_q == S_MEM) && (opcode == OP_SW);
    assign bus.dmem_addr  = alu_q[ADDR_W-1:0];
    assign bus.dmem_wdata = b_q;

    assign flags   = flags_q;
    assign halted  = halted_q;
    assign illegal = illegal_q;
    assign retired = retired_q;

    logic [2:0]  alu_op;
    logic [31:0] alu_b, alu_sum, alu_diff, alu_res;
    logic        alu_v, flag_upd;

    always_comb begin
        alu_op   = ALU_ADD;
        alu_b    = b_q;
        flag_upd = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                flag_upd = 1'b1;
                case (funct)
                    F_SUB:   alu_op = ALU_SUB;
                    F_AND:   alu_op = ALU_AND;
                    F_OR:    alu_op = ALU_OR;
                    F_SLT:   alu_op = ALU_SLT;
                    default: alu_op = ALU_ADD;
                endcase
            end
            OP_ORI:       begin alu_op = ALU_OR;  alu_b = imm_zext; flag_upd = 1'b1; end
            OP_LW, OP_SW: begin alu_op = ALU_ADD; alu_b = imm_sext; end
            OP_BEQ:       begin alu_op = ALU_SUB; flag_upd = 1'b1; end
            OP_REGIMM:    begin alu_op = ALU_SUB; alu_b = '0; flag_upd = 1'b1; end
            default:      ;
        endcase
        alu_sum  = a_q + alu_b;
        alu_diff = a_q - alu_b;
        alu_v    = 1'b0;
        case (alu_op)
            ALU_ADD: begin
                alu_res = alu_sum;
                alu_v   = (a_q[31] == alu_b[31]) && (alu_sum[31] != a_q[31]);
            end
            ALU_SUB: begin
                alu_res = alu_diff;
                alu_v   = (a_q[31] != alu_b[31]) && (alu_diff[31] != a_q[31]);
            end
            ALU_AND: alu_res = a_q & alu_b;
            ALU_OR:  alu_res = a_q | alu_b;
            default: alu_res = {31'd0, $signed(a_q) < $signed(alu_b)};
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        t_d       = t_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        alu_d     = alu_q;
        mdr_d     = mdr_q;
        flags_d   = flags_q;
        halted_d  = halted_q;
        illegal_d = illegal_q;
        retired_d = retired_q;
        rf_we     = 1'b0;
        rf_waddr  = '0;
        rf_wdata  = '0;
        case (state_q)
            S_FETCH: if (bus.imem_ready) begin
                ir_d    = bus.imem_rdata;
                pc_d    = pc_q + ADDR_W'(4);
                state_d = S_DECODE;
            end
            S_DECODE: begin
                a_d = rf_q[rs_idx];
                b_d = rf_q[rt_idx];
                t_d = pc_q + ADDR_W'({imm_sext[29:0], 2'b00});
                if (!op_legal) begin
                    illegal_d = 1'b1;
                    halted_d  = 1'b1;
                    state_d   = S_HALT;
                end else if (opcode == OP_HALT) begin
                    halted_d  = 1'b1;
                    retired_d = retired_q + 32'd1;
                    state_d   = S_HALT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_d = alu_res;
                if (flag_upd) flags_d = {alu_v, alu_res == 32'd0, alu_res[31]};
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEM;
                    OP_BEQ, OP_J, OP_REGIMM: begin
                        if (opcode == OP_BEQ && alu_res == 32'd0) pc_d = t_q;
                        if (opcode == OP_J)
                            pc_d = ADDR_W'((32'(pc_q) & 32'hF000_0000) | {4'h0, ir_q[25:0], 2'b00});
                        // BLTZAL links the already-incremented PC, i.e. the fall-through address.
                        if (opcode == OP_REGIMM && a_q[31]) begin
                            rf_we    = 1'b1;
                            rf_waddr = NREG_LOG2'(LINK_REG);
                            rf_wdata = 32'(pc_q);
                            pc_d     = t_q;
                        end
                        retired_d = retired_q + 32'd1;
                        state_d   = S_FETCH;
                    end
                    default: state_d = S_WB;
                endcase
            end
            S_MEM: if (bus.dmem_ready) begin
                if (opcode == OP_SW) begin
                    retired_d = retired_q + 32'd1;
                    state_d   = S_FETCH;
                end else begin
                    mdr_d   = bus.dmem_rdata;
                    state_d = S_WB;
                end
            end
            S_WB: begin
                rf_we     = 1'b1;
                rf_waddr  = (opcode == OP_RTYPE) ? rd_idx : rt_idx;
                rf_wdata  = (opcode == OP_LW) ? mdr_q : alu_q;
                retired_d = retired_q + 32'd1;
                state_d   = S_FETCH;
            end
            S_HALT:  ;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            pc_q      <= ADDR_W'(RESET_PC);
            t_q       <= '0;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_q     <= '0;
            mdr_q     <= '0;
            flags_q   <= '0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            retired_q <= '0;
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            t_q       <= t_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_q     <= alu_d;
            mdr_q     <= mdr_d;
            flags_q   <= flags_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
            if (rf_we && rf_waddr != '0) rf_q[rf_waddr] <= rf_wdata;
        end
    end
endmodule

// File: tb/tb_mips_lite_mc_core.sv
// Scoreboard bench for mips_lite_mc_core: small programs run against wait-state memory models.
// Every completed store is popped against the expected queue, and end-of-run state is checked.
module tb_mips_lite_mc_core;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  flags;
    logic        halted, illegal;
    logic [31:0] retired;

    mips_lite_mc_core_if #(.ADDR_W(8)) bus ();

    mips_lite_mc_core #(.ADDR_W(8), .NREG_LOG2(5), .RESET_PC(0), .LINK_REG(25)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .flags(flags), .halted(halted), .illegal(illegal), .retired(retired)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] HALT_W = 32'hFC00_0000;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        logic [2:0]  flg;
    } st_t;

    st_t         exp_q[$];
    int          n_vec = 0, n_bad = 0, n_st = 0;
    int          iwait = 0, dwait = 0, icnt, dcnt, dlen = 0;
    logic [31:0] load_val = 32'd0;
    logic [31:0] prog [0:63];
    logic [31:0] dmem [0:63];
    logic [7:0]  last_fa = 8'hFF, fa_after10 = 8'hFF;

    assign bus.imem_ready = bus.imem_req && (icnt >= iwait);
    assign bus.imem_rdata = prog[bus.imem_addr[7:2]];
    assign bus.dmem_ready = bus.dmem_req && (dcnt >= dwait);
    assign bus.dmem_rdata = dmem[bus.dmem_addr[7:2]];

    // Memory models: wait-state counters and data RAM, which reloads its preset value in reset.
    always @(posedge clk) begin
        if (!rst_n) begin
            icnt <= 0;
            dcnt <= 0;
            for (int i = 0; i < 64; i++) dmem[i] <= 32'd0;
            dmem[16] <= load_val;
        end else begin
            icnt <= (bus.imem_req && !bus.imem_ready) ? icnt + 1 : 0;
            dcnt <= (bus.dmem_req && !bus.dmem_ready) ? dcnt + 1 : 0;
            if (bus.dmem_req && bus.dmem_ready && bus.dmem_we)
                dmem[bus.dmem_addr[7:2]] <= bus.dmem_wdata;
        end
    end

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                          input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    task automatic push_st(input logic [7:0] a, input logic [31:0] d, input logic [2:0] f);
        st_t e;
        e.addr = a; e.data = d; e.flg = f;
        exp_q.push_back(e);
    endtask

    // Monitor: one line per completed store; checks handshake length, stores and fetch order.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            dlen = 0;
            last_fa = 8'hFF;
            fa_after10 = 8'hFF;
        end else begin
            if (bus.imem_req && bus.imem_ready) begin
                if (last_fa == 8'h10) fa_after10 = bus.imem_addr;
                last_fa = bus.imem_addr;
            end
            if (bus.dmem_req) begin
                dlen++;
                if (bus.dmem_ready) begin
                    chk_val("dreq_len", 32'(dlen), 32'(dwait + 1));
                    dlen = 0;
                    if (bus.dmem_we) begin
                        n_st++;
                        $display("store addr=%h data=%h flags=%b", bus.dmem_addr, bus.dmem_wdata, flags);
                        if (exp_q.size() == 0) begin
                            chk_val("st_unexpected", {24'd0, bus.dmem_addr}, 32'hFFFF_FFFF);
                        end else begin
                            st_t e;
                            e = exp_q.pop_front();
                            chk_val("st_addr", {24'd0, bus.dmem_addr}, {24'd0, e.addr});
                            chk_val("st_data", bus.dmem_wdata, e.data);
                            chk_val("st_flags", {29'd0, flags}, {29'd0, e.flg});
                        end
                    end
                end
            end
        end
    end

    task automatic clear_prog();
        for (int i = 0; i < 64; i++) prog[i] = HALT_W;
    endtask

    task automatic start(input int iw, input int dw, input logic [31:0] lv);
        @(negedge clk);
        rst_n = 1'b0;
        iwait = iw;
        dwait = dw;
        load_val = lv;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_halt(input string tag);
        for (int k = 0; k < 3000 && !halted; k++) @(negedge clk);
        chk_val(tag, {31'd0, halted}, 32'd1);
    endtask

    task automatic no_fetch_after_halt(input string tag);
        int reqs = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.imem_req || bus.dmem_req) reqs++;
        end
        chk_val(tag, 32'(reqs), 32'd0);
    endtask

    task automatic load_prog_a();
        clear_prog();
        prog[0]  = enc_i(6'h0D, 0, 1, 16'h00FF);   // ori $1,$0,0xFF
        prog[1]  = enc_i(6'h2B, 0, 1, 16'd4);      // sw $1,4($0)
        prog[2]  = enc_i(6'h23, 0, 4, 16'd4);      // lw $4,4($0)
        prog[3]  = enc_i(6'h2B, 0, 4, 16'd8);      // sw $4,8($0)
        prog[4]  = enc_i(6'h23, 0, 6, 16'h0040);   // lw $6,0x40($0)
        prog[5]  = enc_i(6'h0D, 0, 2, 16'd1);      // ori $2,$0,1
        prog[6]  = enc_r(6, 2, 3, 6'h20);          // add $3,$6,$2
        prog[7]  = enc_i(6'h2B, 0, 3, 16'd12);
        prog[8]  = enc_r(3, 2, 7, 6'h22);          // sub $7,$3,$2
        prog[9]  = enc_i(6'h2B, 0, 7, 16'd16);
        prog[10] = enc_r(3, 2, 8, 6'h2A);          // slt $8,$3,$2
        prog[11] = enc_r(1, 6, 9, 6'h24);          // and $9,$1,$6
        prog[12] = enc_r(9, 3, 10, 6'h25);         // or $10,$9,$3
        prog[13] = enc_i(6'h2B, 0, 8, 16'd20);
        prog[14] = enc_i(6'h2B, 0, 10, 16'd24);
        prog[15] = enc_i(6'h0D, 0, 0, 16'd5);      // ori $0,$0,5
        prog[16] = enc_i(6'h2B, 0, 0, 16'd28);
        prog[17] = enc_i(6'h04, 1, 4, 16'd1);      // beq $1,$4,+1 (taken)
        prog[18] = enc_i(6'h2B, 0, 1, 16'd32);     // skipped
        prog[19] = enc_i(6'h2B, 0, 1, 16'd36);
        prog[20] = {6'h02, 26'h16};                // j 0x58
        prog[21] = enc_i(6'h2B, 0, 1, 16'd44);     // skipped
        prog[22] = enc_i(6'h04, 1, 2, 16'd1);      // beq $1,$2,+1 (not taken)
        prog[23] = enc_i(6'h2B, 0, 2, 16'd40);
        prog[24] = HALT_W;
    endtask

    task automatic run_a(input int iw, input int dw, input bit chk_lat);
        load_prog_a();
        start(iw, dw, 32'h7FFF_FFFF);
        push_st(8'd4,  32'h0000_00FF, 3'b000);
        push_st(8'd8,  32'h0000_00FF, 3'b000);
        push_st(8'd12, 32'h8000_0000, 3'b101);
        push_st(8'd16, 32'h7FFF_FFFF, 3'b100);
        push_st(8'd20, 32'h0000_0001, 3'b001);
        push_st(8'd24, 32'h8000_00FF, 3'b001);
        push_st(8'd28, 32'h0000_0000, 3'b000);
        push_st(8'd36, 32'h0000_00FF, 3'b010);
        push_st(8'd40, 32'h0000_0001, 3'b000);
        if (chk_lat) begin
            repeat (3) @(negedge clk);
            chk_val("ori_lat_3", retired, 32'd0);
            @(negedge clk);
            chk_val("ori_lat_4", retired, 32'd1);
            chk_val("ori_flags", {29'd0, flags}, 32'd0);
        end
        wait_halt("a_halt");
        chk_val("a_retired", retired, 32'd23);
        chk_val("a_illegal", {31'd0, illegal}, 32'd0);
        chk_val("a_sb_left", 32'(exp_q.size()), 32'd0);
        no_fetch_after_halt("a_quiet");
    endtask

    task automatic run_b(input logic [31:0] v, input bit taken);
        clear_prog();
        prog[0] = enc_i(6'h23, 0, 5, 16'h0040);    // lw $5,0x40($0)
        prog[1] = enc_i(6'h0D, 0, 9, 16'd0);
        prog[2] = enc_i(6'h0D, 0, 9, 16'd0);
        prog[3] = enc_i(6'h0D, 0, 9, 16'd0);
        prog[4] = {6'h01, 5'd5, 5'b10000, 16'd2};  // bltzal $5,+2 at 0x10
        prog[5] = enc_i(6'h2B, 0, 25, 16'd48);
        prog[6] = HALT_W;
        prog[7] = enc_i(6'h2B, 0, 25, 16'd52);
        prog[8] = HALT_W;
        start(1, 0, v);
        if (taken) push_st(8'd52, 32'h0000_0014, 3'b001);
        else       push_st(8'd48, 32'h0000_0000, 3'b000);
        wait_halt("b_halt");
        chk_val("b_next_fetch", {24'd0, fa_after10}, taken ? 32'h1C : 32'h14);
        chk_val("b_retired", retired, 32'd7);
        chk_val("b_sb_left", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic run_c(input logic [31:0] bad);
        clear_prog();
        prog[0] = enc_i(6'h0D, 0, 1, 16'd1);
        prog[1] = bad;
        prog[2] = enc_i(6'h2B, 0, 1, 16'd0);       // must never run
        start(0, 0, 32'd0);
        wait_halt("c_halt");
        chk_val("c_illegal", {31'd0, illegal}, 32'd1);
        chk_val("c_retired", retired, 32'd1);
        no_fetch_after_halt("c_quiet");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_val("c_rst_halted", {31'd0, halted}, 32'd0);
        chk_val("c_rst_illegal", {31'd0, illegal}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_val("c_refetch_req", {31'd0, bus.imem_req}, 32'd1);
        chk_val("c_refetch_pc", {24'd0, bus.imem_addr}, 32'd0);
    endtask

    initial begin
        clear_prog();
        repeat (3) @(negedge clk);
        chk_val("rst_imem_req", {31'd0, bus.imem_req}, 32'd0);
        chk_val("rst_dmem_req", {31'd0, bus.dmem_req}, 32'd0);
        chk_val("rst_retired", retired, 32'd0);
        chk_val("rst_flags", {29'd0, flags}, 32'd0);
        chk_val("rst_halted", {30'd0, halted, illegal}, 32'd0);

        run_a(0, 2, 1'b1);
        run_a(2, 0, 1'b0);
        run_b(32'hFFFF_FFF0, 1'b1);
        run_b(32'h0000_0001, 1'b0);
        run_c({6'h3E, 26'd0});
        run_c(enc_r(1, 1, 1, 6'h00));

        // Reset dropped while a store waits on dmem_ready.
        clear_prog();
        prog[0] = enc_i(6'h2B, 0, 0, 16'd4);
        start(0, 10, 32'd0);
        for (int k = 0; k < 50 && !bus.dmem_req; k++) @(negedge clk);
        chk_val("d_req_seen", {31'd0, bus.dmem_req}, 32'd1);
        @(negedge clk);
        begin
            int st_before;
            st_before = n_st;
            rst_n = 1'b0;
            #1;
            chk_val("d_req_drop", {31'd0, bus.dmem_req}, 32'd0);
            chk_val("d_retired", retired, 32'd0);
            repeat (15) @(negedge clk);
            chk_val("d_no_store", 32'(n_st), 32'(st_before));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
